// File: rtl/apb_slave_regfile.sv
// APB completer with a small 32-bit register file and programmable wait states.
// Ports:
//   pclk, presetn        - clock (rising edge), asynchronous active-low reset
//   psel/penable/pwrite  - APB control; slave responds when psel == SLAVE_ID
//   paddr/pwdata         - byte address and write data
//   pready/prdata/pslverr- registered response (held for one cycle)
//   status_in            - read-only value returned for register NUM_REGS-1
//   ctrl_out             - continuous copy of register 0
//   wr_strobe/wr_index   - one-cycle pulse and index on each successful write
module apb_slave_regfile #(
    parameter logic [1:0]  SLAVE_ID    = 2'd1,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                        pclk,
    input  logic                        presetn,
    input  logic [1:0]                  psel,
    input  logic                        penable,
    input  logic                        pwrite,
    input  logic [31:0]                 paddr,
    input  logic [31:0]                 pwdata,
    output logic                        pready,
    output logic [31:0]                 prdata,
    output logic                        pslverr,
    input  logic [31:0]                 status_in,
    output logic [31:0]                 ctrl_out,
    output logic                        wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0] wr_index
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam int unsigned CNT_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pready_q, pready_d;
    logic [31:0]        prdata_q, prdata_d;
    logic               pslverr_q, pslverr_d;
    logic               wr_strobe_q, wr_strobe_d;
    logic [IDX_W-1:0]   wr_index_q, wr_index_d;
    logic [31:0]        regs_q [NUM_REGS];
    logic [31:0]        regs_d [NUM_REGS];

    logic               sel_c;
    logic [IDX_W-1:0]   idx_c;
    logic               valid_c;

    // Address decode: aligned, in range, and not a write to the status window.
    always_comb begin
        sel_c   = (psel == SLAVE_ID);
        idx_c   = paddr[2 +: IDX_W];
        valid_c = (paddr[1:0] == 2'b00) && (paddr < ADDR_LIMIT)
                  && !(pwrite && (idx_c == LAST_IDX));
    end

    // Next-state and response logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pready_d    = pready_q;
        prdata_d    = prdata_q;
        pslverr_d   = pslverr_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;
        regs_d      = regs_q;

        unique case (state_q)
            ST_IDLE: begin
                // A penable seen without a prior setup cycle is treated as setup.
                if (sel_c) begin
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!sel_c) begin
                    state_d = ST_IDLE;
                end else if (penable) begin
                    if (cnt_q != CNT_W'(0)) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        pready_d = 1'b1;
                        state_d  = ST_RESP;
                        if (!valid_c) begin
                            prdata_d  = 32'd0;
                            pslverr_d = 1'b1;
                        end else if (pwrite) begin
                            regs_d[idx_c] = pwdata;
                            wr_strobe_d   = 1'b1;
                            wr_index_d    = idx_c;
                            pslverr_d     = 1'b0;
                        end else begin
                            prdata_d  = (idx_c == LAST_IDX) ? status_in : regs_q[idx_c];
                            pslverr_d = 1'b0;
                        end
                    end
                end
            end
            ST_RESP: begin
                // Response lasts one cycle; any new setup here is ignored.
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pready_q    <= 1'b0;
            prdata_q    <= '0;
            pslverr_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pready_q    <= pready_d;
            prdata_q    <= prdata_d;
            pslverr_q   <= pslverr_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
            regs_q      <= regs_d;
        end
    end

    assign pready    = pready_q;
    assign prdata    = prdata_q;
    assign pslverr   = pslverr_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
    assign ctrl_out  = regs_q[0];

endmodule
